// File: rtl/sid_audio_out.sv
// sid_audio_out: boxcar decimator for the SID 1 MHz audio stream, mono-duplicated I2S
// serialiser and an optional first-order sigma-delta DAC pin (build macro SID_AUDIO_SDM_EN).
module sid_audio_out #(
    parameter int DECIM_LOG2 = 5,
    parameter int BCLK_DIV   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic [15:0] audio_in,
    output logic [15:0] sample_out,
    output logic        sample_stb,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        dac_out
);
    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [7:0]       DIV_TERM = 8'(BCLK_DIV - 1);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0]        r_cnt;
    logic [15:0]             r_sample;
    logic                    r_stb;

    logic [7:0]  r_div;
    logic        r_bclk;
    logic [4:0]  r_slot;
    logic        r_lrck;
    logic        r_sdata;
    logic [15:0] r_frame;
    logic        w_div_term;
    logic        w_fall;
    logic [4:0]  w_slot_nxt;
    logic [3:0]  w_bit_idx;

    assign w_in_ext = ACC_W'($signed(audio_in));
    assign w_sum    = r_acc + w_in_ext;

    // Decimator: accumulate 2^DECIM_LOG2 strikes; the top 16 bits of the sum are the floor average.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= {ACC_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_sample <= 16'h0000;
            r_stb    <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (ce_1m) begin
                if (r_cnt == CNT_TERM) begin
                    r_sample <= w_sum[ACC_W-1:DECIM_LOG2];
                    r_acc    <= {ACC_W{1'b0}};
                    r_cnt    <= {CNT_W{1'b0}};
                    r_stb    <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign w_div_term = (r_div == DIV_TERM);
    assign w_fall     = w_div_term & r_bclk;
    assign w_slot_nxt = r_slot + 5'd1;
    // Slot k of each half carries F[16-k]; k=0 wraps to F[0], giving the one-bit I2S delay.
    assign w_bit_idx  = 4'd0 - w_slot_nxt[3:0];

    // BCLK divider, slot counter and serialiser; everything moves on the BCLK falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= 8'd0;
            r_bclk  <= 1'b0;
            r_slot  <= 5'd0;
            r_lrck  <= 1'b0;
            r_sdata <= 1'b0;
            r_frame <= 16'h0000;
        end else begin
            if (w_div_term) begin
                r_div  <= 8'd0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + 8'd1;
            end
            if (w_fall) begin
                r_slot  <= w_slot_nxt;
                r_lrck  <= w_slot_nxt[4];
                r_sdata <= r_frame[w_bit_idx];
                if (w_slot_nxt == 5'd0) begin
                    r_frame <= r_sample;
                end
            end
        end
    end

`ifdef SID_AUDIO_SDM_EN
    logic [15:0] r_sdm_acc;
    logic        r_dac;
    logic [16:0] w_sdm_sum;

    assign w_sdm_sum = {1'b0, r_sdm_acc} + {1'b0, ~r_sample[15], r_sample[14:0]};

    // First-order sigma-delta: the adder carry is the output bit stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdm_acc <= 16'h0000;
            r_dac     <= 1'b0;
        end else begin
            r_sdm_acc <= w_sdm_sum[15:0];
            r_dac     <= w_sdm_sum[16];
        end
    end

    assign dac_out = r_dac;
`else
    assign dac_out = 1'b0;
`endif

    assign sample_out = r_sample;
    assign sample_stb = r_stb;
    assign i2s_bclk   = r_bclk;
    assign i2s_lrck   = r_lrck;
    assign i2s_sdata  = r_sdata;
endmodule

// File: tb/tb_sid_audio_out.sv
// Bench for sid_audio_out: table-driven decimation vectors with a sample scoreboard,
// plus hand-written I2S frame capture, mid-frame reset and DAC sequences.
module tb_sid_audio_out;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce_1m;
    logic [15:0] audio_in;
    logic [15:0] sample_out,  o0_sample;
    logic        sample_stb,  o0_stb;
    logic        i2s_bclk,    o0_bclk;
    logic        i2s_lrck,    o0_lrck;
    logic        i2s_sdata,   o0_sdata;
    logic        dac_out,     o0_dac;

    always #5 clk = ~clk;

    sid_audio_out #(.DECIM_LOG2(5), .BCLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .audio_in(audio_in),
        .sample_out(sample_out), .sample_stb(sample_stb), .i2s_bclk(i2s_bclk),
        .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata), .dac_out(dac_out));

    sid_audio_out #(.DECIM_LOG2(0), .BCLK_DIV(1)) dut0 (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .audio_in(audio_in),
        .sample_out(o0_sample), .sample_stb(o0_stb), .i2s_bclk(o0_bclk),
        .i2s_lrck(o0_lrck), .i2s_sdata(o0_sdata), .dac_out(o0_dac));

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic        alt;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          strikes_since = 0;
    int          dac_ones = 0;
    int          dac0_ones = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic strike(input logic [15:0] v);
        @(negedge clk);
        ce_1m = 1'b1;
        audio_in = v;
        strikes_since++;
        @(negedge clk);
        ce_1m = 1'b0;
        check("d0_sample", {16'h0000, o0_sample}, {16'h0000, v});
        check("d0_stb", {31'd0, o0_stb}, 32'd1);
        repeat (30) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sample_out"}, {16'h0000, sample_out}, 32'd0);
        check({tag, "_sample_stb"}, {31'd0, sample_stb}, 32'd0);
        check({tag, "_bclk"},       {31'd0, i2s_bclk},   32'd0);
        check({tag, "_lrck"},       {31'd0, i2s_lrck},   32'd0);
        check({tag, "_sdata"},      {31'd0, i2s_sdata},  32'd0);
        check({tag, "_dac"},        {31'd0, dac_out},    32'd0);
    endtask

    // Scoreboard consumer: every strobe must match the queued expectation, be one clk wide
    // and arrive exactly 32 strikes after the previous one.
    initial begin
        logic prev_stb;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_out) dac_ones++;
            if (o0_dac) dac0_ones++;
            if (sample_stb) begin
                if (exp_q.size() == 0) begin
                    check("stb_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sample_out", {16'h0000, sample_out}, {16'h0000, exp_q.pop_front()});
                end
                check("strikes_between", strikes_since, 32'd32);
                check("stb_width", {31'd0, prev_stb}, 32'd0);
                strikes_since = 0;
            end
            prev_stb = sample_stb;
        end
    end

    initial begin
        logic [15:0] v;
        logic        p;
        logic        pb;
        logic        psd;
        logic        ok;
        logic [32:0] bits;
        logic [32:0] lr;
        logic [32:0] lr_exp;
        logic [15:0] left;
        logic [15:0] right;
        int          cnt;
        int          cyc;
        int          last;
        int          unstable;
        int          first_bclk;
        int          first_lrck;

        vecs[0] = '{16'h1000, 16'h0000, 1'b0, 16'h1000};
        vecs[1] = '{16'h7FFF, 16'h8001, 1'b1, 16'h0000};
        vecs[2] = '{16'h8000, 16'h0000, 1'b0, 16'h8000};
        vecs[3] = '{16'h0000, 16'h0001, 1'b0, 16'h000F};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFEF};
        vecs[5] = '{16'h7FFF, 16'h0000, 1'b0, 16'h7FFF};
        vecs[6] = '{16'hA5C3, 16'h0000, 1'b0, 16'hA5C3};

        reset = 1'b1;
        ce_1m = 1'b0;
        audio_in = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check("d0_reset_sample", {16'h0000, o0_sample}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i].exp);
            for (int k = 0; k < 32; k++) begin
                if (vecs[i].alt) v = (k % 2 == 1) ? vecs[i].step : vecs[i].base;
                else v = 16'(vecs[i].base + 16'(k) * vecs[i].step);
                strike(v);
            end
        end
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        // I2S frame capture: sample_out now holds A5C3.
        repeat (8) @(negedge clk);
        ok = 1'b0;
        p = i2s_lrck;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (p && !i2s_lrck) ok = 1'b1;
            p = i2s_lrck;
        end
        check("lrck_fall_seen", {31'd0, ok}, 32'd1);
        cnt = 0; cyc = 0; last = -1; unstable = 0;
        pb = i2s_bclk; psd = i2s_sdata;
        bits = '0; lr = '0;
        while (cnt < 33 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!pb && i2s_bclk) begin
                bits[cnt] = i2s_sdata;
                lr[cnt] = i2s_lrck;
                if (i2s_sdata !== psd) unstable++;
                if (last >= 0 && cnt < 4) check("bclk_period", cyc - last, 32'd4);
                last = cyc;
                cnt++;
            end
            pb = i2s_bclk;
            psd = i2s_sdata;
        end
        check("capture_count", cnt, 32'd33);
        check("sdata_stable_at_rise", unstable, 32'd0);
        for (int j = 0; j < 16; j++) begin
            left[15-j] = bits[1+j];
            right[15-j] = bits[17+j];
        end
        lr_exp = {1'b0, {16{1'b1}}, {16{1'b0}}};
        check("i2s_left", {16'h0000, left}, 32'h0000A5C3);
        check("i2s_right", {16'h0000, right}, 32'h0000A5C3);
        check("lrck_pattern", lr[31:0], lr_exp[31:0]);
        check("lrck_slot32", {31'd0, lr[32]}, 32'd0);

        // Mid-frame reset with a partially filled accumulator.
        for (int k = 0; k < 10; k++) strike(16'h7FFF);
        ok = 1'b0;
        p = i2s_lrck;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (!p && i2s_lrck) ok = 1'b1;
            p = i2s_lrck;
        end
        check("lrck_rise_seen", {31'd0, ok}, 32'd1);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        strikes_since = 0;
        check_reset_state("midreset");
        first_bclk = -1; first_lrck = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) check("lrck_after_release", {31'd0, i2s_lrck}, 32'd0);
            if (i2s_bclk && first_bclk < 0) first_bclk = c;
            if (i2s_lrck && first_lrck < 0) first_lrck = c;
        end
        check("first_bclk_rise", first_bclk, 32'd2);
        check("first_lrck_rise", first_lrck, 32'd64);
        exp_q.push_back(16'h0100);
        for (int k = 0; k < 32; k++) strike(16'h0100);
        repeat (4) @(negedge clk);
        check("acc_restart_drained", exp_q.size(), 32'd0);

`ifdef SID_AUDIO_SDM_EN
        exp_q.push_back(16'h4000);
        for (int k = 0; k < 32; k++) strike(16'h4000);
        repeat (4) @(negedge clk);
        dac_ones = 0;
        repeat (65536) @(negedge clk);
        check("dac_density_ok", {31'd0, (dac_ones >= 49151 && dac_ones <= 49153)}, 32'd1);
`else
        check("dac_stays_zero", dac_ones, 32'd0);
        check("d0_dac_stays_zero", dac0_ones, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
